// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: the snooped CPU write port and the
// DMA master bus toward the memory unit.
interface oam_dma_if;
  // CPU write port, snooped to catch the trigger register write
  logic        z80_write_n;
  logic [15:0] z80_address;
  logic [7:0]  z80_dout;
  // DMA master bus
  logic        dma_mreq_n;
  logic        dma_read_n;
  logic        dma_write_n;
  logic [15:0] dma_address;
  logic [7:0]  dma_dout;
  logic [7:0]  dma_din;
  logic        dma_wait_n;
  // Arbitration and register readback
  logic        dma_active;
  logic [7:0]  dma_src;

  // DMA engine side
  modport master (
    input  z80_write_n, z80_address, z80_dout, dma_din, dma_wait_n,
    output dma_mreq_n, dma_read_n, dma_write_n, dma_address, dma_dout,
           dma_active, dma_src
  );

  // CPU / memory-unit side
  modport slave (
    output z80_write_n, z80_address, z80_dout, dma_din, dma_wait_n,
    input  dma_mreq_n, dma_read_n, dma_write_n, dma_address, dma_dout,
           dma_active, dma_src
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to the trigger register copies LEN bytes from
// page {src,00} to DST_BASE, one READ cycle and one WRITE cycle per byte.
// Bus outputs are decoded from registered state, so an asynchronous reset
// takes the bus off immediately.
module oam_dma #(
  parameter int          LEN      = 160,
  parameter logic [15:0] DST_BASE = 16'hFE00,
  parameter logic [15:0] REG_ADDR = 16'hFF46
) (
  input logic      clk,
  input logic      Reset_n,
  oam_dma_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  localparam logic [7:0] LAST_INDEX = 8'(LEN - 1);

  logic [1:0] state_reg;
  logic [7:0] index_reg;
  logic [7:0] data_reg;
  logic [7:0] src_reg;
  logic       trigger;
  logic [7:0] page;

  // A trigger always wins, even over a stall or the final write completion
  assign trigger = !bus.z80_write_n && (bus.z80_address == REG_ADDR);

  // Source pages E0..FF fold down onto C0..DF
  assign page = (src_reg < 8'hE0) ? src_reg : (src_reg - 8'h20);

  // Transfer sequencer: trigger register, state, byte index and data latch
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_IDLE;
      index_reg <= 8'h00;
      data_reg  <= 8'h00;
      src_reg   <= 8'h00;
    end else if (trigger) begin
      src_reg   <= bus.z80_dout;
      index_reg <= 8'h00;
      state_reg <= ST_START;
    end else begin
      case (state_reg)
        ST_START: begin
          index_reg <= 8'h00;
          state_reg <= ST_READ;
        end
        ST_READ: begin
          if (bus.dma_wait_n) begin
            data_reg  <= bus.dma_din;
            state_reg <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (bus.dma_wait_n) begin
            if (index_reg == LAST_INDEX) begin
              state_reg <= ST_IDLE;
            end else begin
              index_reg <= index_reg + 8'd1;
              state_reg <= ST_READ;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Bus decode from state; idle/start leave every strobe released
  always_comb begin
    bus.dma_mreq_n  = 1'b1;
    bus.dma_read_n  = 1'b1;
    bus.dma_write_n = 1'b1;
    bus.dma_address = 16'h0000;
    case (state_reg)
      ST_READ: begin
        bus.dma_mreq_n  = 1'b0;
        bus.dma_read_n  = 1'b0;
        bus.dma_address = {page, index_reg};
      end
      ST_WRITE: begin
        bus.dma_mreq_n  = 1'b0;
        bus.dma_write_n = 1'b0;
        bus.dma_address = DST_BASE + {8'h00, index_reg};
      end
      default: ;
    endcase
  end

  assign bus.dma_dout   = data_reg;
  assign bus.dma_active = (state_reg != ST_IDLE);
  assign bus.dma_src    = src_reg;

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter LEN, default 160, SHALL give the number of bytes copied per transfer (1..256).
REQ-002 Parameter DST_BASE, default 16'hFE00, SHALL give the destination base address.
REQ-003 Parameter REG_ADDR, default 16'hFF46, SHALL give the CPU-visible trigger register address.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 z80_write_n  input  1  CPU write strobe, active low (snooped).
REQ-007 z80_address  input  16  CPU address (snooped).
REQ-008 z80_dout  input  8  CPU write data (snooped).
REQ-009 dma_mreq_n  output  1  DMA memory request, active low.
REQ-010 dma_read_n  output  1  DMA read strobe, active low.
REQ-011 dma_write_n  output  1  DMA write strobe, active low.
REQ-012 dma_address  output  16  DMA bus address.
REQ-013 dma_dout  output  8  DMA write data.
REQ-014 dma_din  input  8  read data returned by the memory unit.
REQ-015 dma_wait_n  input  1  memory ready; low stalls the current DMA cycle.
REQ-016 dma_active  output  1  high while a transfer owns the bus (CPU arbitration uses it).
REQ-017 dma_src  output  8  last value written to REG_ADDR (register readback).

Function
REQ-018 Trigger: a clk edge with z80_write_n=0 and z80_address=REG_ADDR SHALL load dma_src<=z80_dout and enter START.
REQ-019 Source page: effective page = dma_src if dma_src<8'hE0, else dma_src-8'h20 (E0..FF fold to C0..DF).
REQ-020 States: IDLE, START, READ, WRITE; IDLE->START on trigger only.
REQ-021 START: one cycle, bus idle (all strobes high), index<=0, dma_active=1; then READ.
REQ-022 READ: dma_mreq_n=0, dma_read_n=0, dma_write_n=1, dma_address={page,index}; at edge with dma_wait_n=1 latch dma_din into data register, go WRITE.
REQ-023 WRITE: dma_mreq_n=0, dma_write_n=0, dma_read_n=1, dma_address=DST_BASE+index, dma_dout=latched byte; at edge with dma_wait_n=1: if index==LEN-1 go IDLE, else index+1 and go READ.
REQ-024 Index SHALL be 8 bits; no wrap occurs because transfer ends at LEN-1.
REQ-025 dma_wait_n=0 in READ or WRITE SHALL hold state, index, latched data and all bus outputs unchanged.
REQ-026 Throughput: with dma_wait_n=1, transfer occupies exactly 1+2*LEN cycles from trigger edge to IDLE.
REQ-027 dma_active SHALL be 1 in START/READ/WRITE, 0 in IDLE, registered with state.
REQ-028 IDLE/START outputs: strobes all 1, dma_address=16'h0000, dma_dout holds last value.
REQ-029 Re-trigger during START/READ/WRITE SHALL abort current transfer and restart at START with new dma_src; bytes already written stay written.
REQ-030 Re-trigger on the same edge as the final WRITE completion SHALL win: next state START, not IDLE.
REQ-031 Re-trigger while dma_wait_n=0 SHALL still restart (trigger overrides stall).
REQ-032 dma_read_n and dma_write_n SHALL never both be 0 in any cycle.

Reset
REQ-033 Reset_n=0 SHALL immediately force IDLE, index=0, data register=0, dma_src=8'h00, dma_dout=8'h00, dma_address=16'h0000, all strobes 1, dma_active=0.
REQ-034 Reset mid-transfer SHALL abandon it; after release the block stays IDLE until a new trigger.
REQ-035 Triggers presented while Reset_n=0 SHALL be ignored.

Verification
REQ-036 Write 8'hC1 to FF46, wait_n=1, memory C100..C19F = index pattern -> FE00..FE9F match, dma_active high exactly 321 cycles, dma_src=8'hC1.
REQ-037 Write 8'hE3 to FF46 -> first READ address 16'hC300, last WRITE address 16'hFE9F.
REQ-038 Hold dma_wait_n=0 for 3 cycles during READ of index 5 -> address C105 held 4 cycles, no skipped or duplicated destination byte, total 324 cycles.
REQ-039 Write 8'hC0 then, at index 40, write 8'hD0 -> next cycle START, then READ D000, WRITE FE00; FE00..FE27 end with D0xx data.
REQ-040 Assert Reset_n=0 during WRITE of index 10 -> same-cycle strobes high, dma_active=0, dma_src=00; no further bus activity after release.
REQ-041 Trigger coincident with final WRITE completion -> START follows, dma_active stays 1 without a gap.
